// File: rtl/rapid_recovery_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rapid_recovery_pkg
// Description : Shared types and helpers for the HMR rapid-recovery scheduler.
//               Holds the scheduler FSM state encoding and a modulo helper
//               used by the round-robin picker and the pointer update.
// Revision    : 1.0 - initial release
// ============================================================================
package rapid_recovery_pkg;

    // Scheduler FSM states. Encoding is fixed so waveforms read consistently.
    typedef enum logic [1:0] {
        RR_IDLE  = 2'd0,
        RR_START = 2'd1,
        RR_WAIT  = 2'd2,
        RR_DONE  = 2'd3
    } rr_state_e;

    // Single-step modulo wrap for a value known to be below 2*n.
    // Avoids a full divider for non-power-of-two group counts.
    function automatic int rr_wrap(input int a, input int n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage : rapid_recovery_pkg
`default_nettype wire

// File: rtl/hmr_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : hmr_rr_picker
// Description : Round-robin selector. Rotates the eligible vector so that the
//               pointer position lands on bit 0, finds the first set bit of the
//               rotated vector, then un-rotates that offset back into a group
//               index. Purely combinational.
// Ports       : eligible_i - candidate groups (one bit per group)
//               ptr_i      - group with highest priority this round
//               valid_o    - at least one candidate present
//               idx_o      - selected group index (0 when valid_o is low)
// Revision    : 1.0 - initial release
// ============================================================================
module hmr_rr_picker
    import rapid_recovery_pkg::*;
#(
    parameter int NumGroups = 4
) (
    input  logic [NumGroups-1:0]         eligible_i,
    input  logic [$clog2(NumGroups)-1:0] ptr_i,
    output logic                         valid_o,
    output logic [$clog2(NumGroups)-1:0] idx_o
);

    localparam int c_ID_W = $clog2(NumGroups);

    logic [NumGroups-1:0] w_rot;
    logic [c_ID_W-1:0]    w_src;
    logic [c_ID_W-1:0]    w_off;

    // Rotate right by the pointer: w_rot[j] is group (ptr + j) mod NumGroups.
    always_comb begin
        w_rot = '0;
        w_src = '0;
        for (int j = 0; j < NumGroups; j++) begin
            w_src    = c_ID_W'(rr_wrap(j + int'(ptr_i), NumGroups));
            w_rot[j] = eligible_i[w_src];
        end
    end

    // Distance from the pointer to the first candidate: scanning downward
    // leaves the lowest set position as the final assignment.
    always_comb begin
        w_off = '0;
        for (int j = NumGroups - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = c_ID_W'(j);
            end
        end
    end

    assign valid_o = |eligible_i;
    assign idx_o   = valid_o ? c_ID_W'(rr_wrap(int'(ptr_i) + int'(w_off), NumGroups))
                             : '0;

endmodule : hmr_rr_picker
`default_nettype wire

// File: rtl/hmr_recovery_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hmr_recovery_scheduler
// Description : Shares one rapid-recovery controller among NumGroups core
//               groups. Records per-group requests, picks a group round-robin,
//               routes the controller to it, and waits for completion or a
//               timeout. Groups that time out are marked faulty and ignored
//               until a global clear.
// Ports       : clk_i               - clock
//               rst_ni              - asynchronous active-low reset
//               req_i               - per-group recovery request
//               enable_i            - per-group arbitration mask
//               clear_fault_i       - pulse clearing all sticky faults
//               grant_o             - one-hot routing select
//               start_recovery_o    - one-cycle start pulse to the controller
//               recovery_finished_i - completion pulse from the controller
//               busy_o              - FSM not idle
//               active_id_o         - granted group index (0 when idle)
//               timeout_o           - one-cycle pulse on abandoned recovery
//               fault_o             - sticky per-group timeout flags
//               recovery_count_o    - saturating completed-recovery count
// Revision    : 1.0 - initial release
// ============================================================================
module hmr_recovery_scheduler
    import rapid_recovery_pkg::*;
#(
    parameter int NumGroups     = 4,
    parameter int TimeoutCycles = 1024,
    parameter int CntWidth      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumGroups-1:0]         req_i,
    input  logic [NumGroups-1:0]         enable_i,
    input  logic                         clear_fault_i,
    output logic [NumGroups-1:0]         grant_o,
    output logic                         start_recovery_o,
    input  logic                         recovery_finished_i,
    output logic                         busy_o,
    output logic [$clog2(NumGroups)-1:0] active_id_o,
    output logic                         timeout_o,
    output logic [NumGroups-1:0]         fault_o,
    output logic [CntWidth-1:0]          recovery_count_o
);

    localparam int                c_ID_W     = $clog2(NumGroups);
    localparam int                c_TMR_W    = $clog2(TimeoutCycles);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TimeoutCycles - 1);

    rr_state_e            r_state;
    rr_state_e            w_state_next;

    logic [NumGroups-1:0] r_pending;
    logic [NumGroups-1:0] r_fault;
    logic [c_ID_W-1:0]    r_active_id;
    logic [c_ID_W-1:0]    r_rr_ptr;
    logic [c_TMR_W-1:0]   r_timer;
    logic [CntWidth-1:0]  r_count;

    logic [NumGroups-1:0] w_req_valid;
    logic [NumGroups-1:0] w_eligible;
    logic [NumGroups-1:0] w_active_oh;
    logic [NumGroups-1:0] w_done_clr;
    logic [NumGroups-1:0] w_timeout_set;
    logic [NumGroups-1:0] w_pending_next;
    logic [NumGroups-1:0] w_fault_next;
    logic [NumGroups-1:0] w_grant;
    logic [c_ID_W-1:0]    w_pick_idx;
    logic [c_ID_W-1:0]    w_next_ptr;
    logic                 w_pick_valid;
    logic                 w_start;
    logic                 w_timeout;
    logic                 w_finish_ok;
    logic                 w_busy;

    // ------------------------------------------------------------------------
    // Request bookkeeping
    // ------------------------------------------------------------------------
    // Recorded requests exclude faulted groups. Arbitration also looks at the
    // live request so a request in IDLE starts on the very next cycle.
    assign w_req_valid = req_i & enable_i & ~r_fault;
    assign w_eligible  = (r_pending | (req_i & enable_i)) & ~r_fault;
    assign w_active_oh = NumGroups'(1) << r_active_id;

    // The served bit is cleared in DONE, but a request arriving in the same
    // cycle re-sets it (set has priority). Faulted groups lose pending bits.
    assign w_done_clr     = (r_state == RR_DONE) ? w_active_oh : '0;
    assign w_pending_next = ((r_pending & ~w_done_clr) | w_req_valid) & ~r_fault;

    // Global clear beats a timeout that lands in the same cycle.
    assign w_timeout_set = w_timeout ? w_active_oh : '0;
    assign w_fault_next  = clear_fault_i ? '0 : (r_fault | w_timeout_set);

    assign w_next_ptr = c_ID_W'(rr_wrap(int'(r_active_id) + 1, NumGroups));

    hmr_rr_picker #(
        .NumGroups (NumGroups)
    ) u_picker (
        .eligible_i (w_eligible),
        .ptr_i      (r_rr_ptr),
        .valid_o    (w_pick_valid),
        .idx_o      (w_pick_idx)
    );

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_grant      = '0;
        w_timeout    = 1'b0;
        w_finish_ok  = 1'b0;
        case (r_state)
            RR_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = RR_START;
                end
            end
            RR_START: begin
                w_start      = 1'b1;
                w_grant      = w_active_oh;
                w_state_next = RR_WAIT;
            end
            RR_WAIT: begin
                w_grant = w_active_oh;
                // Completion wins over a coinciding timeout.
                if (recovery_finished_i) begin
                    w_finish_ok  = 1'b1;
                    w_state_next = RR_DONE;
                end else if (r_timer == c_TMR_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = RR_DONE;
                end
            end
            RR_DONE: begin
                w_state_next = RR_IDLE;
            end
            default: begin
                w_state_next = RR_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending   <= '0;
            r_fault     <= '0;
            r_active_id <= '0;
            r_rr_ptr    <= '0;
            r_timer     <= '0;
            r_count     <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_fault   <= w_fault_next;

            if ((r_state == RR_IDLE) && w_pick_valid) begin
                r_active_id <= w_pick_idx;
            end

            if (r_state == RR_DONE) begin
                r_rr_ptr <= w_next_ptr;
            end

            if (r_state == RR_WAIT) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end else if (r_state == RR_DONE) begin
                r_timer <= '0;
            end

            if (w_finish_ok && (r_count != '1)) begin
                r_count <= r_count + CntWidth'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign w_busy           = (r_state != RR_IDLE);
    assign busy_o           = w_busy;
    assign grant_o          = w_grant;
    assign start_recovery_o = w_start;
    assign active_id_o      = w_busy ? r_active_id : '0;
    assign timeout_o        = w_timeout;
    assign fault_o          = r_fault;
    assign recovery_count_o = r_count;

endmodule : hmr_recovery_scheduler
`default_nettype wire

// File: doc/hmr_recovery_scheduler.md
HMR_RECOVERY_SCHEDULER -- requirements
Module: hmr_recovery_scheduler

Interface
REQ-001 SHALL have parameter NumGroups, default 4, number of core groups sharing one rapid-recovery controller (2..16).
REQ-002 SHALL have parameter TimeoutCycles, default 1024, maximum WAIT duration before a recovery is abandoned (>=2).
REQ-003 SHALL have parameter CntWidth, default 16, width of the completed-recovery counter.
REQ-004 SHALL have port clk_i  input  1  clock.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_i  input  NumGroups  per-group recovery request, level or pulse.
REQ-007 SHALL have port enable_i  input  NumGroups  per-group arbitration mask; 0 means requests are ignored and not recorded.
REQ-008 SHALL have port clear_fault_i  input  1  one-cycle pulse clearing all sticky faults.
REQ-009 SHALL have port grant_o  output  NumGroups  one-hot routing select of the shared controller/backup path.
REQ-010 SHALL have port start_recovery_o  output  1  one-cycle start pulse to the controller.
REQ-011 SHALL have port recovery_finished_i  input  1  completion pulse from the controller.
REQ-012 SHALL have port busy_o  output  1  high whenever the FSM is not IDLE.
REQ-013 SHALL have port active_id_o  output  $clog2(NumGroups)  index of the granted group; 0 when idle.
REQ-014 SHALL have port timeout_o  output  1  one-cycle pulse on abandoned recovery.
REQ-015 SHALL have port fault_o  output  NumGroups  sticky per-group timeout flag.
REQ-016 SHALL have port recovery_count_o  output  CntWidth  saturating count of completed recoveries.

Function
REQ-017 SHALL implement FSM states IDLE, START, WAIT, DONE.
REQ-018 SHALL record requests: pending_q[i] is set when req_i[i] & enable_i[i] & ~fault_q[i].
REQ-019 SHALL arbitrate in IDLE over eligible = (pending_q | req_i & enable_i) & ~fault_q; when eligible is non-zero, pick round-robin starting at rr_ptr_q, latch active_id, and go to START.
REQ-020 SHALL give a 1-cycle request-to-start latency: req_i high in IDLE at cycle t yields start_recovery_o high at cycle t+1.
REQ-021 SHALL, in START, assert start_recovery_o for exactly one cycle, assert grant_o[active_id], and go to WAIT.
REQ-022 SHALL, in WAIT, hold grant_o and increment the timer each cycle.
REQ-023 SHALL, in WAIT on recovery_finished_i: increment recovery_count_o (saturating at all-ones) and go to DONE.
REQ-024 SHALL, in WAIT when the timer reaches TimeoutCycles-1 without recovery_finished_i: pulse timeout_o, set fault_q[active_id], and go to DONE.
REQ-025 SHALL treat finished as winning when recovery_finished_i and timeout coincide in the same cycle (count only, no fault).
REQ-026 SHALL, in DONE: deassert grant_o, clear pending_q[active_id], set rr_ptr_q to (active_id+1) mod NumGroups, clear the timer, and go to IDLE.
REQ-027 SHALL give set priority over clear when req_i[active_id] is high during DONE; that request stays pending.
REQ-028 SHALL ignore recovery_finished_i outside WAIT.
REQ-029 SHALL ignore requests from faulted groups, and SHALL drop pending bits of groups whose fault is set.
REQ-030 SHALL, on clear_fault_i, clear all fault_q bits the next cycle; clear wins over a simultaneous timeout set.
REQ-031 SHALL keep grant_o zero or one-hot at all times; it is zero in IDLE and DONE.
REQ-032 SHALL apply a mid-recovery enable_i deassertion only to future arbitration, never aborting the active group.

Reset
REQ-033 SHALL, on reset, put the FSM in IDLE; clear pending_q, fault_q, rr_ptr_q, timer and counter to 0; and drive every output 0.
REQ-034 SHALL apply reset asynchronously at any state, including WAIT, abandoning the recovery without a timeout_o pulse.

Structure
REQ-035 SHALL place the scheduler state enum in rapid_recovery_pkg; parameters stay local.
REQ-036 SHALL build the round-robin pick as one sub-module, hmr_rr_picker (rotate by pointer, leading-zero count, un-rotate); the remaining logic stays in a single module of 120-400 RTL lines.

Verification
REQ-037 SHALL cover: req_i=4'b0100 in IDLE -> start_recovery_o at t+1, grant_o=4'b0100; finished after 10 cycles -> grant drops and recovery_count_o=1.
REQ-038 SHALL cover: req_i=4'b1111 held, finished after 5 cycles each -> service order 0,1,2,3,0 with no double starts.
REQ-039 SHALL cover: TimeoutCycles=8, no finished -> timeout_o pulses in the 8th WAIT cycle and fault_o[id]=1; a further req from that group is ignored until clear_fault_i.
REQ-040 SHALL cover: recovery_finished_i on the cycle of the timeout -> no fault and count increments.
REQ-041 SHALL cover: req_i[active] reasserted in DONE -> the same group is re-served only after the other pending groups (round-robin).
REQ-042 SHALL cover: rst_ni low during WAIT -> all outputs 0 asynchronously; after release, a new request starts normally.
